twiddle_mult_stage: RTL and testbench



---
 rtl/fft_pkg.sv | 31 +++
 rtl/cmul_rs.sv | 75 +++++++
 rtl/twiddle_mult_stage.sv | 67 ++++++
 tb/tb_twiddle_mult_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, complex sample type and round/saturate helper
package fft_pkg;

    localparam int TW_ONE    = 512;
    localparam int TW_FRAC   = 9;
    localparam int TW_ADDR_W = 6;
    localparam int SAMPLE_W  = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    // Round half-up at bit frac-1, drop frac bits, clamp to a w-bit signed range.
    function automatic logic signed [63:0] round_shift_sat(input logic signed [63:0] x,
                                                           input int frac, input int w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmul_rs.sv
// rtl/cmul_rs.sv - 3-stage complex multiplier with round/saturate and bypass passthrough
module cmul_rs
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = TW_FRAC
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_en,
    input  logic                    in_bypass,
    input  logic                    in_last,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  cplx_t                   tw,
    output logic                    out_en,
    output logic                    out_last,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im
);

    localparam int PW = WIDTH + 17;

    logic                    s1_en, s1_byp, s1_last;
    logic signed [WIDTH-1:0] s1_re, s1_im;
    logic                    s2_en, s2_byp, s2_last;
    logic signed [WIDTH-1:0] s2_re, s2_im;
    logic signed [PW-1:0]    s2_pr, s2_pi;
    logic signed [PW-1:0]    pr_c, pi_c;

    // Twiddle arrives one cycle after the address, so it pairs with the S1 sample.
    assign pr_c = PW'(s1_re) * PW'(tw.re) - PW'(s1_im) * PW'(tw.im);
    assign pi_c = PW'(s1_re) * PW'(tw.im) + PW'(s1_im) * PW'(tw.re);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_en    <= 1'b0;
            s1_byp   <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_en    <= 1'b0;
            s2_byp   <= 1'b0;
            s2_last  <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
            s2_pr    <= '0;
            s2_pi    <= '0;
            out_en   <= 1'b0;
            out_last <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
        end else begin
            s1_en    <= in_en;
            s1_byp   <= in_bypass;
            s1_last  <= in_en & in_last;
            s1_re    <= in_re;
            s1_im    <= in_im;
            s2_en    <= s1_en;
            s2_byp   <= s1_byp;
            s2_last  <= s1_last;
            s2_re    <= s1_re;
            s2_im    <= s1_im;
            s2_pr    <= pr_c;
            s2_pi    <= pi_c;
            out_en   <= s2_en;
            out_last <= s2_last;
            if (s2_en) begin
                out_re <= s2_byp ? s2_re : WIDTH'(round_shift_sat(64'(s2_pr), FRAC, WIDTH));
                out_im <= s2_byp ? s2_im : WIDTH'(round_shift_sat(64'(s2_pi), FRAC, WIDTH));
            end
        end
    end

endmodule

// File: rtl/twiddle_mult_stage.sv
// rtl/twiddle_mult_stage.sv - SDF inter-stage twiddle address generator and multiplier
module twiddle_mult_stage #(
    parameter int WIDTH   = 16,
    parameter int LOG_M   = 6,
    parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             di_en,
    input  logic signed [WIDTH-1:0]          di_re,
    input  logic signed [WIDTH-1:0]          di_im,
    output logic [fft_pkg::TW_ADDR_W-1:0]    tw_addr,
    input  logic signed [15:0]               tw_re,
    input  logic signed [15:0]               tw_im,
    output logic                             do_en,
    output logic signed [WIDTH-1:0]          do_re,
    output logic signed [WIDTH-1:0]          do_im,
    output logic                             do_last
);

    import fft_pkg::*;

    logic [LOG_M-1:0]     cnt;
    logic [1:0]           sel;
    logic [TW_ADDR_W-1:0] p_ext;
    logic [TW_ADDR_W-1:0] prod;
    cplx_t                tw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (di_en) begin
            cnt <= cnt + LOG_M'(1);
        end
    end

    // At LOG_M=2 there are no position bits, so every factor is unity.
    if (LOG_M > 2) begin : g_pos
        assign p_ext = TW_ADDR_W'(cnt[LOG_M-3:0]);
    end else begin : g_pos_none
        assign p_ext = '0;
    end

    assign sel     = {cnt[LOG_M-2], cnt[LOG_M-1]};
    assign prod    = p_ext * TW_ADDR_W'(sel);
    assign tw_addr = prod << (TW_ADDR_W - LOG_M);
    assign tw      = '{re: tw_re, im: tw_im};

    cmul_rs #(
        .WIDTH (WIDTH),
        .FRAC  (TW_FRAC)
    ) u_cmul (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_en     (di_en),
        .in_bypass (tw_addr == '0),
        .in_last   (cnt == '1),
        .in_re     (di_re),
        .in_im     (di_im),
        .tw        (tw),
        .out_en    (do_en),
        .out_last  (do_last),
        .out_re    (do_re),
        .out_im    (do_im)
    );

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// tb/tb_twiddle_mult_stage.sv - self-checking bench for twiddle_mult_stage
module tb_twiddle_mult_stage;
    import fft_pkg::*;

    localparam int N = 64;

    typedef struct {
        bit                 en;
        bit                 last;
        logic signed [15:0] re;
        logic signed [15:0] im;
    } out_t;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               di_en = 1'b0;
    logic signed [15:0] di_re = '0;
    logic signed [15:0] di_im = '0;
    logic [5:0]         tw_addr;
    logic signed [15:0] tw_re, tw_im;
    logic               do_en, do_last;
    logic signed [15:0] do_re, do_im;

    logic signed [15:0] tbl_re [64];
    logic signed [15:0] tbl_im [64];

    int                 errors = 0;
    int                 checks = 0;
    int                 frame_idx = 0;
    int                 st = 0;
    int                 exp_addr = 0;
    int                 en_cnt = 0;
    int                 last_cnt = 0;
    int                 last_pos = 0;
    bit                 drv_en;
    logic [5:0]         obs_addr;
    out_t               exp_now;
    out_t               pend [int];
    logic signed [15:0] held_re = '0;
    logic signed [15:0] held_im = '0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        tw_re <= tbl_re[tw_addr];
        tw_im <= tbl_im[tw_addr];
    end

    twiddle_mult_stage #(.WIDTH(16), .LOG_M(6), .TW_FRAC(9)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .di_en   (di_en),
        .di_re   (di_re),
        .di_im   (di_im),
        .tw_addr (tw_addr),
        .tw_re   (tw_re),
        .tw_im   (tw_im),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_last (do_last)
    );

    function automatic int model_addr(input int k);
        int q, p, blk, sel;
        q   = N / 4;
        p   = k % q;
        blk = k / q;
        sel = (blk % 2) * 2 + blk / 2;
        return p * sel * (64 / N);
    endfunction

    function automatic logic signed [15:0] sat16(input longint v);
        longint r;
        r = (v + longint'(TW_ONE / 2)) >>> TW_FRAC;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    function automatic int rnd_val();
        int k;
        k = int'($urandom_range(0, 7));
        if (k == 0) return -32768;
        if (k == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_clear();
        frame_idx = 0;
        pend.delete();
        held_re = '0;
        held_im = '0;
    endtask

    // One clock of stimulus: drive at the falling edge, land on the next falling edge.
    task automatic cycle(input bit en, input int re, input int im);
        out_t   o;
        longint pr, pi;
        int     a;
        di_en  = en;
        di_re  = 16'(re);
        di_im  = 16'(im);
        drv_en = en;
        st++;
        if (en) begin
            a        = model_addr(frame_idx);
            exp_addr = a;
            o.en     = 1'b1;
            o.last   = (frame_idx == N - 1);
            if (a == 0) begin
                o.re = di_re;
                o.im = di_im;
            end else begin
                pr   = longint'(di_re) * longint'(tbl_re[a]) - longint'(di_im) * longint'(tbl_im[a]);
                pi   = longint'(di_re) * longint'(tbl_im[a]) + longint'(di_im) * longint'(tbl_re[a]);
                o.re = sat16(pr);
                o.im = sat16(pi);
            end
            pend[st + 2] = o;
            frame_idx = (frame_idx + 1) % N;
        end
        #1 obs_addr = tw_addr;
        @(posedge clock);
        @(negedge clock);
        if (pend.exists(st)) begin
            exp_now = pend[st];
            pend.delete(st);
            held_re = exp_now.re;
            held_im = exp_now.im;
        end else begin
            exp_now = '{en: 1'b0, last: 1'b0, re: held_re, im: held_im};
        end
        if (do_en === 1'b1) en_cnt++;
        if (do_last === 1'b1) begin
            last_cnt++;
            last_pos = en_cnt;
        end
    endtask

    // mode: 0 random, 1 constant (100,50) every cycle, 2 valid pattern 1,0,0,1, 3 idle
    task automatic run(input string name, input int n, input int mode, input int target);
        int steps;
        bit en;
        int re, im;
        steps = 0;
        while (steps < n && (target < 0 || frame_idx != target)) begin
            case (mode)
                0:       en = ($urandom_range(0, 3) != 0);
                1:       en = 1'b1;
                2:       en = (steps % 4 == 0) || (steps % 4 == 3);
                default: en = 1'b0;
            endcase
            re = (mode == 1) ? 100 : rnd_val();
            im = (mode == 1) ? 50 : rnd_val();
            cycle(en, re, im);
            checks++;
            if ({do_en, do_last, do_re, do_im} !== {exp_now.en, exp_now.last, exp_now.re, exp_now.im}) begin
                errors++;
                $display("FAIL %s step %0d: got en=%b last=%b re=%0d im=%0d, want en=%b last=%b re=%0d im=%0d",
                         name, st, do_en, do_last, do_re, do_im, exp_now.en, exp_now.last, exp_now.re, exp_now.im);
            end
            if (drv_en) begin
                checks++;
                if (obs_addr !== 6'(exp_addr)) begin
                    errors++;
                    $display("FAIL %s_addr step %0d: got %0d, want %0d", name, st, obs_addr, exp_addr);
                end
            end
            steps++;
        end
        if (target >= 0) begin
            checks++;
            if (frame_idx != target) begin
                errors++;
                $display("FAIL %s_bound: cnt %0d, want %0d within %0d cycles", name, frame_idx, target, n);
            end
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        di_en   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        int re0, im0;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            di_en = 1'b1;
            di_re = 16'(rnd_val());
            di_im = 16'(rnd_val());
            @(negedge clock);
            checks++;
            if ({do_en, do_last, do_re, do_im, tw_addr} !== '0) begin
                errors++;
                $display("FAIL reset_hold: got en=%b last=%b re=%0d im=%0d addr=%0d, want all 0",
                         do_en, do_last, do_re, do_im, tw_addr);
            end
        end
        di_en   = 1'b0;
        reset_n = 1'b1;
        model_clear();
        re0 = rnd_val();
        im0 = rnd_val();
        cycle(1'b1, re0, im0);
        checks++;
        if (do_en !== 1'b0 || obs_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_first_t1: got en=%b addr=%0d, want en=0 addr=0", do_en, obs_addr);
        end
        cycle(1'b0, 0, 0);
        checks++;
        if (do_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_t2: got en=%b, want 0", do_en);
        end
        cycle(1'b0, 0, 0);
        checks++;
        if (do_en !== 1'b1 || do_re !== 16'(re0) || do_im !== 16'(im0)) begin
            errors++;
            $display("FAIL reset_first_t3: got en=%b (%0d,%0d), want en=1 (%0d,%0d)", do_en, do_re, do_im, re0, im0);
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        en_cnt   = 0;
        last_cnt = 0;
        last_pos = 0;
        run("bypass", 64, 1, -1);
        run("bypass_drain", 4, 3, -1);
        checks++;
        if (en_cnt != 64 || last_cnt != 1 || last_pos != 64) begin
            errors++;
            $display("FAIL bypass_frame: got valid=%0d last=%0d at %0d, want 64, 1 at 64", en_cnt, last_cnt, last_pos);
        end
    endtask

    task automatic test_rotation();
        run("rot_lead", 300, 0, 24);
        cycle(1'b1, 100, 50);
        checks++;
        if (obs_addr !== 6'd16) begin
            errors++;
            $display("FAIL rot_addr: got %0d, want 16", obs_addr);
        end
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        checks++;
        if (do_en !== 1'b1 || do_re !== 16'sd50 || do_im !== -16'sd100) begin
            errors++;
            $display("FAIL rot_out: got en=%b (%0d,%0d), want en=1 (50,-100)", do_en, do_re, do_im);
        end
    endtask

    task automatic test_rounding();
        run("rnd_lead", 300, 0, 40);
        cycle(1'b1, 3, 0);
        checks++;
        if (obs_addr !== 6'd8) begin
            errors++;
            $display("FAIL rnd_addr: got %0d, want 8", obs_addr);
        end
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        checks++;
        if (do_en !== 1'b1 || do_re !== 16'sd2 || do_im !== -16'sd2) begin
            errors++;
            $display("FAIL rnd_out: got en=%b (%0d,%0d), want en=1 (2,-2)", do_en, do_re, do_im);
        end
    endtask

    task automatic test_saturation();
        run("sat_lead", 300, 0, 40);
        cycle(1'b1, 32767, 32767);
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        checks++;
        if (do_en !== 1'b1 || do_re !== 16'sd32767 || do_im !== -16'sd64) begin
            errors++;
            $display("FAIL sat_out: got en=%b (%0d,%0d), want en=1 (32767,-64)", do_en, do_re, do_im);
        end
    endtask

    task automatic test_back_to_back();
        run("b2b", 200, 0, -1);
    endtask

    task automatic test_gaps();
        run("gaps_pre", 4, 3, -1);
        en_cnt = 0;
        run("gaps", 32, 2, -1);
        run("gaps_drain", 4, 3, -1);
        checks++;
        if (en_cnt != 16) begin
            errors++;
            $display("FAIL gaps_count: got %0d valid outputs, want 16", en_cnt);
        end
    endtask

    task automatic test_midframe_reset();
        run("mr_lead", 300, 0, 37);
        reset_n = 1'b0;
        di_en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            di_re = 16'(rnd_val());
            di_im = 16'(rnd_val());
            #1;
            checks++;
            if ({do_en, do_last, do_re, do_im, tw_addr} !== '0) begin
                errors++;
                $display("FAIL mr_hold: got en=%b last=%b re=%0d im=%0d addr=%0d, want all 0",
                         do_en, do_last, do_re, do_im, tw_addr);
            end
            @(negedge clock);
        end
        di_en   = 1'b0;
        reset_n = 1'b1;
        model_clear();
        run("mr_idle", 4, 3, -1);
        cycle(1'b1, 777, -555);
        checks++;
        if (obs_addr !== 6'd0) begin
            errors++;
            $display("FAIL mr_addr: got %0d, want 0", obs_addr);
        end
        cycle(1'b0, 0, 0);
        cycle(1'b0, 0, 0);
        checks++;
        if (do_en !== 1'b1 || do_re !== 16'sd777 || do_im !== -16'sd555) begin
            errors++;
            $display("FAIL mr_out: got en=%b (%0d,%0d), want en=1 (777,-555)", do_en, do_re, do_im);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tbl_re[i] = 16'($urandom);
            tbl_im[i] = 16'($urandom);
        end
        tbl_re[16] = 16'sd0;
        tbl_im[16] = -16'sd512;
        tbl_re[8]  = 16'sd362;
        tbl_im[8]  = -16'sd363;
        test_reset();
        test_bypass();
        test_rotation();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_gaps();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
